bit_reverse_seq: RTL and testbench

Parametrised, sequential successor to the combinational bit reverser. It reverses the order of 2^mode-bit groups within a WIDTH-bit word, so one block covers bit reverse, nibble reverse, byte reverse and so on. The reversal is iterative, STEP groups per clock, which trades latency for area. The block sits on a valid/ready stream between datapath stages.

---
 rtl/bit_reverse_seq.sv | 145 ++++++++++++++
 tb/tb_bit_reverse_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_reverse_seq.sv
`default_nettype none
// ============================================================================
// Module      : bit_reverse_seq
// Description : Iterative group reverser on a valid/ready stream. It swaps the
//               order of 2^mode-bit groups in a WIDTH-bit word, retiring STEP
//               groups per busy cycle. Optional macro BITREV_BYPASS_EN adds an
//               in_bypass port that returns the word unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_reverse_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int MW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [MW-1:0]    in_mode,
`ifdef BITREV_BYPASS_EN
    input  logic             in_bypass,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int c_LOG2W = $clog2(WIDTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_src;
    logic [WIDTH-1:0] r_dst;
    logic [MW-1:0]    r_cnt;
    logic [MW-1:0]    r_mode;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_busy;

    logic [MW-1:0]    w_mode_eff;
    logic [MW-1:0]    w_gsz;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_src;
    logic [WIDTH-1:0] w_dst;
    logic [MW-1:0]    w_cnt;

    // Modes above log2(WIDTH) collapse to one full-width group (identity).
    assign w_mode_eff = (in_mode > MW'(c_LOG2W)) ? MW'(c_LOG2W) : in_mode;
    assign w_gsz      = MW'(1) << r_mode;
    assign w_mask     = ~({WIDTH{1'b1}} << w_gsz);

    // Shift up to STEP groups out of src (LSB first) and into dst, so the
    // first group taken ends up in the most significant position.
    always_comb begin
        w_src = r_src;
        w_dst = r_dst;
        w_cnt = r_cnt;
        for (int i = 0; i < STEP; i++) begin
            if (w_cnt != '0) begin
                w_dst = (w_dst << w_gsz) | (w_src & w_mask);
                w_src = w_src >> w_gsz;
                w_cnt = w_cnt - MW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_cnt       <= '0;
            r_mode      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
`ifdef BITREV_BYPASS_EN
                        if (in_bypass) begin
                            r_state     <= c_DONE;
                            r_out_valid <= 1'b1;
                            r_out_data  <= in_data;
                        end else begin
`else
                        begin
`endif
                            r_state <= c_BUSY;
                            r_busy  <= 1'b1;
                            r_src   <= in_data;
                            r_dst   <= '0;
                            r_mode  <= w_mode_eff;
                            r_cnt   <= MW'(WIDTH >> w_mode_eff);
                        end
                    end
                end
                c_BUSY: begin
                    r_src <= w_src;
                    r_dst <= w_dst;
                    r_cnt <= w_cnt;
                    if (w_cnt == '0) begin
                        r_state     <= c_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_dst;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state     <= c_IDLE;
                        r_out_valid <= 1'b0;
                        r_out_data  <= '0;
                        r_in_ready  <= 1'b1;
                        r_src       <= '0;
                        r_dst       <= '0;
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bit_reverse_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_reverse_seq
// Description : Self-checking bench for bit_reverse_seq (WIDTH=32, STEP=4):
//               directed vector table, reset abort, backpressure, random run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_reverse_seq;

    localparam int c_WIDTH = 32;
    localparam int c_STEP  = 4;
    localparam int c_MW    = $clog2(c_WIDTH) + 1;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [c_WIDTH-1:0]  in_data;
    logic [c_MW-1:0]     in_mode;
    logic                out_valid;
    logic                out_ready;
    logic [c_WIDTH-1:0]  out_data;
    logic                busy;
`ifdef BITREV_BYPASS_EN
    logic                in_bypass;
`endif

    int n_tests;
    int n_fail;

    bit_reverse_seq #(.WIDTH(c_WIDTH), .STEP(c_STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
`ifdef BITREV_BYPASS_EN
        .in_bypass (in_bypass),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  mode;
        logic [31:0] exp;
        int          k;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Golden model: move every bit individually to its destination group.
    function automatic logic [31:0] golden(input logic [31:0] d, input int mode);
        logic [31:0] r;
        int m, g, n;
        m = (mode > 5) ? 5 : mode;
        g = 1 << m;
        n = c_WIDTH / g;
        r = '0;
        for (int b = 0; b < c_WIDTH; b++)
            r[(n - 1 - (b / g)) * g + (b % g)] = d[b];
        return r;
    endfunction

    // Send one word, measure latency and busy cycles, then drain it.
    task automatic do_word(input logic [31:0] d, input logic [5:0] mode,
                           input logic [31:0] exp, input int kexp,
                           input bit rnd_ready, input bit check_k);
        int k, nb, t;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = mode;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_mode  = 6'($urandom_range(0, 63));
        k  = 0;
        nb = 0;
        while (!out_valid && k < 64) begin
            if (busy) nb++;
            @(posedge clk);
            #1;
            k++;
        end
        if (!out_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: out_valid never rose (data 0x%08h mode %0d)", d, mode);
            return;
        end
        check("result", out_data, exp);
        if (check_k) begin
            check("latency", 32'(k), 32'(kexp));
            check("busy_cycles", 32'(nb), 32'(kexp));
        end
        t = 0;
        do begin
            @(negedge clk);
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!out_ready) check("held_data", out_data, exp);
            @(posedge clk);
            #1;
            t++;
        end while (!(out_ready && !out_valid) && t < 200);
        @(negedge clk);
        out_ready = 1'b0;
        if (out_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: out_valid still 1 after handshake window");
        end
        if (!rnd_ready) begin
            check("in_ready_after_hs", 32'(in_ready), 32'd1);
            check("out_data_idle", out_data, 32'd0);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        out_ready = 1'b0;
`ifdef BITREV_BYPASS_EN
        in_bypass = 1'b0;
`endif
        vecs[0] = '{32'h00000001, 6'd0, 32'h80000000, 8};
        vecs[1] = '{32'h12345678, 6'd0, 32'h1E6A2C48, 8};
        vecs[2] = '{32'h11223344, 6'd3, 32'h44332211, 1};
        vecs[3] = '{32'h12345678, 6'd2, 32'h87654321, 2};
        vecs[4] = '{32'hDEADBEEF, 6'd5, 32'hDEADBEEF, 1};
        vecs[5] = '{32'hDEADBEEF, 6'd7, 32'hDEADBEEF, 1};
        vecs[6] = '{32'h12345678, 6'd4, 32'h56781234, 1};
        vecs[7] = '{32'h000000E4, 6'd1, 32'h1B000000, 4};

        rst = 1'b1;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i])
            do_word(vecs[i].data, vecs[i].mode, vecs[i].exp, vecs[i].k, 1'b0, 1'b1);

        // Reset during the third busy cycle aborts the word.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h00000001;
        in_mode  = 6'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_word(32'h12345678, 6'd0, 32'h1E6A2C48, 8, 1'b0, 1'b1);

        // Backpressure: hold the result for 20 cycles while inputs wiggle.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h11223344;
        in_mode  = 6'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_valid", 32'(out_valid), 32'd1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            in_data  = $urandom;
            in_mode  = 6'($urandom_range(0, 7));
            @(posedge clk);
            #1;
            check("bp_data", out_data, 32'h44332211);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_busy", 32'(busy), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_hs_valid", 32'(out_valid), 32'd0);
        check("bp_hs_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;

        // Random words and modes with random downstream readiness.
        for (int r = 0; r < 1000; r++) begin
            logic [31:0] d;
            int          md, m, kk;
            d  = $urandom;
            md = $urandom_range(0, 7);
            m  = (md > 5) ? 5 : md;
            kk = ((c_WIDTH >> m) + c_STEP - 1) / c_STEP;
            do_word(d, 6'(md), golden(d, md), kk, 1'b1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
